// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiplier family: mode encoding, latency,
// and elaboration-time helpers that size the carry-save reduction tree.
package mul_pkg;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  localparam int unsigned MUL_LATENCY   = 3;
  localparam int unsigned MUL_WIDTH_MIN = 4;
  localparam int unsigned MUL_WIDTH_MAX = 32;

  // Rows left after lvl layers of 3:2 compression, starting from n0 rows.
  function automatic int unsigned csa_rows_after(int unsigned n0, int unsigned lvl);
    int unsigned n;
    n = n0;
    for (int unsigned i = 0; i < lvl; i++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  // Number of compression layers needed to reach two rows.
  function automatic int unsigned csa_levels(int unsigned n0);
    int unsigned n;
    int unsigned l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l++;
    end
    return l;
  endfunction

  // Index of the first row of layer lvl inside the flattened row store.
  function automatic int unsigned csa_row_offset(int unsigned n0, int unsigned lvl);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < lvl; i++) begin
      off += csa_rows_after(n0, i);
    end
    return off;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit 3:2 compressor cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/half_adder.sv
// Single-bit 2:2 compressor cell.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i;
  assign co_o = a_i & b_i;

endmodule

// File: rtl/wallace_csa_tree.sv
// Combinational Wallace reduction of a WIDTH x WIDTH partial-product array to sum/carry
// rows, with Baugh-Wooley correction applied when sgn_i is set.
module wallace_csa_tree
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0][WIDTH-1:0] pp_i,   // pp_i[i][j] = a[j] & b[i]
  input  logic                        sgn_i,
  output logic [2*WIDTH-1:0]          sum_o,
  output logic [2*WIDTH-1:0]          carry_o
);

  localparam int unsigned P     = 2 * WIDTH;
  localparam int unsigned N0    = WIDTH + 1;  // WIDTH shifted rows plus one constant row
  localparam int unsigned NLEV  = csa_levels(N0);
  localparam int unsigned LAST  = csa_row_offset(N0, NLEV);
  localparam int unsigned TOTAL = LAST + 2;

  logic [P-1:0] row0 [N0];
  logic [P-1:0] rows [TOTAL];

  // Baugh-Wooley: cross terms of the sign row/column are inverted, the corner term is not.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      row0[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        row0[i][i+j] = pp_i[i][j] ^ (sgn_i & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    row0[WIDTH]        = '0;
    row0[WIDTH][WIDTH] = sgn_i;
    row0[WIDTH][P-1]   = sgn_i;
  end

  for (genvar r = 0; r < N0; r++) begin : g_row0
    assign rows[r] = row0[r];
  end

  for (genvar l = 0; l < NLEV; l++) begin : g_lvl
    localparam int unsigned N  = csa_rows_after(N0, l);
    localparam int unsigned OI = csa_row_offset(N0, l);
    localparam int unsigned OO = csa_row_offset(N0, l + 1);
    localparam int unsigned G  = N / 3;

    for (genvar g = 0; g < G; g++) begin : g_fa
      logic [P-1:0] s;
      logic [P-2:0] c;
      for (genvar k = 0; k < P - 1; k++) begin : g_bit
        full_adder u_fa (
          .a_i  (rows[OI+3*g][k]),
          .b_i  (rows[OI+3*g+1][k]),
          .c_i  (rows[OI+3*g+2][k]),
          .s_o  (s[k]),
          .co_o (c[k])
        );
      end
      // Carry out of the top column falls outside the modulo-2^P result.
      assign s[P-1] = rows[OI+3*g][P-1] ^ rows[OI+3*g+1][P-1] ^ rows[OI+3*g+2][P-1];
      assign rows[OO+2*g]   = s;
      assign rows[OO+2*g+1] = {c, 1'b0};
    end

    if (N % 3 == 1) begin : g_pass
      assign rows[OO+2*G] = rows[OI+3*G];
    end else if (N % 3 == 2) begin : g_ha
      logic [P-1:0] s;
      logic [P-2:0] c;
      for (genvar k = 0; k < P - 1; k++) begin : g_bit
        half_adder u_ha (
          .a_i  (rows[OI+3*G][k]),
          .b_i  (rows[OI+3*G+1][k]),
          .s_o  (s[k]),
          .co_o (c[k])
        );
      end
      assign s[P-1] = rows[OI+3*G][P-1] ^ rows[OI+3*G+1][P-1];
      assign rows[OO+2*G]   = s;
      assign rows[OO+2*G+1] = {c, 1'b0};
    end
  end

  assign sum_o   = rows[LAST];
  assign carry_o = rows[LAST+1];

endmodule

// File: rtl/wallace_mul_pipe.sv
// Three-stage pipelined Wallace-tree multiplier (unsigned or signed per operation) with
// valid/ready handshakes on both sides and full back-pressure.
module wallace_mul_pipe
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned PW = 2 * WIDTH;

  if (WIDTH < MUL_WIDTH_MIN || WIDTH > MUL_WIDTH_MAX) begin : g_bad_width
    $error("wallace_mul_pipe: WIDTH must lie in 4..32");
  end

  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;
  logic adv1, adv2, adv3, load1;

  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic [PW-1:0]    sum_q, carry_q, prod_q;

  logic [WIDTH-1:0][WIDTH-1:0] pp;
  logic [PW-1:0]               sum_d, carry_d, prod_d;

  // Ready ripples back from out_ready through the chain; there is no skid buffer.
  always_comb begin
    adv3     = v3_q & out_ready;
    adv2     = v2_q & (~v3_q | adv3);
    adv1     = v1_q & (~v2_q | adv2);
    in_ready = ~v1_q | adv1;
    load1    = in_valid & in_ready;
    v1_d     = load1 | (v1_q & ~adv1);
    v2_d     = adv1 | (v2_q & ~adv2);
    v3_d     = adv2 | (v3_q & ~adv3);
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = a_q & {WIDTH{b_q[i]}};
    end
  end

  wallace_csa_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .pp_i    (pp),
    .sgn_i   (sgn_q == MODE_SIGNED),
    .sum_o   (sum_d),
    .carry_o (carry_d)
  );

  assign prod_d = sum_q + carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= MODE_UNSIGNED;
      tag1_q  <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      tag2_q  <= '0;
      prod_q  <= '0;
      tag3_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (load1) begin
        a_q    <= in_a;
        b_q    <= in_b;
        sgn_q  <= in_signed;
        tag1_q <= in_tag;
      end
      if (adv1) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        tag2_q  <= tag1_q;
      end
      if (adv2) begin
        prod_q <= prod_d;
        tag3_q <= tag2_q;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_prod  = prod_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Directed and scoreboarded bench for wallace_mul_pipe at WIDTH 8, 5 (exhaustive) and 16.
module tb_wallace_mul_pipe;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    logic [3:0]  tag;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
    longint x, y, p;
    x = {48'b0, a};
    y = {48'b0, b};
    if (s) begin
      if (a[w-1]) x -= (64'sd1 <<< w);
      if (b[w-1]) y -= (64'sd1 <<< w);
    end
    p = (x * y) & ((64'sd1 <<< (2 * w)) - 1);
    return p[31:0];
  endfunction

  // WIDTH = 8 instance
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_prod;
  logic [31:0] exp8_cur;
  exp_t        q8[$];

  wallace_mul_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_prod(out_prod), .out_tag(out_tag)
  );

  // WIDTH = 5 instance
  logic        v5_in_valid, v5_in_ready, v5_in_signed, v5_out_valid;
  logic [4:0]  v5_in_a, v5_in_b;
  logic [3:0]  v5_in_tag, v5_out_tag;
  logic [9:0]  v5_out_prod;
  logic [31:0] exp5_cur;
  exp_t        q5[$];

  wallace_mul_pipe #(.WIDTH(5), .TAG_W(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5_in_valid), .in_ready(v5_in_ready),
    .in_a(v5_in_a), .in_b(v5_in_b), .in_signed(v5_in_signed), .in_tag(v5_in_tag),
    .out_valid(v5_out_valid), .out_ready(1'b1), .out_prod(v5_out_prod),
    .out_tag(v5_out_tag)
  );

  // WIDTH = 16 instance
  logic        v16_in_valid, v16_in_ready, v16_in_signed, v16_out_valid;
  logic [15:0] v16_in_a, v16_in_b;
  logic [3:0]  v16_in_tag, v16_out_tag;
  logic [31:0] v16_out_prod;
  logic [31:0] exp16_cur;
  exp_t        q16[$];

  wallace_mul_pipe #(.WIDTH(16), .TAG_W(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16_in_valid), .in_ready(v16_in_ready),
    .in_a(v16_in_a), .in_b(v16_in_b), .in_signed(v16_in_signed), .in_tag(v16_in_tag),
    .out_valid(v16_out_valid), .out_ready(1'b1), .out_prod(v16_out_prod),
    .out_tag(v16_out_tag)
  );

  // Scoreboards: sampled mid-cycle, pop before push so nothing matches itself.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        check("w8_pending", 32'(q8.size() > 0), 32'd1);
        if (q8.size() > 0) begin
          check("w8_prod", 32'(out_prod), q8[0].prod);
          check("w8_tag", 32'(out_tag), 32'(q8[0].tag));
          void'(q8.pop_front());
        end
      end
      if (in_valid && in_ready) q8.push_back('{prod: exp8_cur, tag: in_tag});

      if (v5_out_valid) begin
        check("w5_pending", 32'(q5.size() > 0), 32'd1);
        if (q5.size() > 0) begin
          check("w5_prod", 32'(v5_out_prod), q5[0].prod);
          check("w5_tag", 32'(v5_out_tag), 32'(q5[0].tag));
          void'(q5.pop_front());
        end
      end
      if (v5_in_valid && v5_in_ready) q5.push_back('{prod: exp5_cur, tag: v5_in_tag});

      if (v16_out_valid) begin
        check("w16_pending", 32'(q16.size() > 0), 32'd1);
        if (q16.size() > 0) begin
          check("w16_prod", v16_out_prod, q16[0].prod);
          check("w16_tag", 32'(v16_out_tag), 32'(q16[0].tag));
          void'(q16.pop_front());
        end
      end
      if (v16_in_valid && v16_in_ready) q16.push_back('{prod: exp16_cur, tag: v16_in_tag});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the operation on the inputs until accepted; leaves in_valid high on return.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [3:0] tag, input logic [31:0] exp);
    logic got;
    got = 1'b0;
    in_a = a; in_b = b; in_signed = s; in_tag = tag; exp8_cur = exp; in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #1;
      got = in_ready;
      tick();
      if (got) return;
    end
    check("send8_accept", 32'(got), 32'd1);
  endtask

  logic [15:0] hold;
  int          acc;
  logic [7:0]  ra, rb;
  logic        rs;

  initial begin
    in_valid = 0; in_a = 0; in_b = 0; in_signed = 0; in_tag = 0; out_ready = 1; exp8_cur = 0;
    v5_in_valid = 0; v5_in_a = 0; v5_in_b = 0; v5_in_signed = 0; v5_in_tag = 0; exp5_cur = 0;
    v16_in_valid = 0; v16_in_a = 0; v16_in_b = 0; v16_in_signed = 0; v16_in_tag = 0;
    exp16_cur = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_prod", 32'(out_prod), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Latency: capture edge plus two more edges
    send8(8'hFF, 8'hFF, MODE_UNSIGNED, 4'd3, 32'hFE01);
    in_valid = 0;
    check("lat_e1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_e2_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_e3_valid", 32'(out_valid), 32'd1);
    check("lat_prod", 32'(out_prod), 32'hFE01);
    check("lat_tag", 32'(out_tag), 32'd3);
    tick();
    check("lat_empty", 32'(out_valid), 32'd0);

    // Directed signed corners, mixed modes back-to-back
    send8(8'h80, 8'h80, MODE_SIGNED, 4'd1, 32'h4000);
    send8(8'hFF, 8'h01, MODE_SIGNED, 4'd2, 32'hFFFF);
    send8(8'h7F, 8'h80, MODE_SIGNED, 4'd4, 32'hC080);
    send8(8'h80, 8'hFF, MODE_UNSIGNED, 4'd5, 32'h7F80);
    send8(8'h80, 8'h01, MODE_SIGNED, 4'd6, 32'hFF80);
    send8(8'hFF, 8'hFF, MODE_SIGNED, 4'd7, 32'h0001);
    in_valid = 0;
    repeat (5) tick();
    check("dir_drained", 32'(q8.size()), 32'd0);

    // Full-throughput random stream
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
      send8(ra, rb, rs, 4'(i), ref_mul(8, {8'b0, ra}, {8'b0, rb}, rs));
      if (i >= 2) check("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 0;
    repeat (5) tick();
    check("stream_drained", 32'(q8.size()), 32'd0);

    // Back-pressure: only three operations fit
    out_ready = 0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_a = 8'(8'h91 + 16 * acc); in_b = 8'(8'h2B + 7 * acc); in_signed = acc[0];
      in_tag = 4'(8 + acc); exp8_cur = ref_mul(8, {8'b0, in_a}, {8'b0, in_b}, in_signed);
      in_valid = 1;
      #1;
      if (in_ready) acc++;
      tick();
    end
    check("bp_accepted", 32'(acc), 32'd3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    hold = out_prod;
    tick();
    check("bp_prod_stable", 32'(out_prod), 32'(hold));
    out_ready = 1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0;
    repeat (6) tick();
    check("bp_drained", 32'(q8.size()), 32'd0);

    // Reset with two operations in flight
    out_ready = 0;
    send8(8'h12, 8'h34, MODE_UNSIGNED, 4'd10, 32'h03A8);
    send8(8'h56, 8'h78, MODE_UNSIGNED, 4'd11, 32'h2850);
    in_valid = 0;
    tick();
    check("rstm_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_async_valid", 32'(out_valid), 32'd0);
    check("rstm_async_prod", 32'(out_prod), 32'd0);
    q8.delete();
    tick();
    rst_n = 1'b1;
    out_ready = 1;
    repeat (6) begin
      tick();
      check("rstm_no_stale", 32'(out_valid), 32'd0);
    end
    check("rstm_in_ready", 32'(in_ready), 32'd1);

    // WIDTH = 5 exhaustive, both modes
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 32; a++) begin
        for (int b = 0; b < 32; b++) begin
          v5_in_a = 5'(a); v5_in_b = 5'(b); v5_in_signed = 1'(s); v5_in_tag = 4'(a + b);
          exp5_cur = ref_mul(5, 16'(a), 16'(b), 1'(s));
          v5_in_valid = 1;
          tick();
        end
      end
    end
    v5_in_valid = 0;
    repeat (5) tick();
    check("w5_drained", 32'(q5.size()), 32'd0);

    // WIDTH = 16 random
    for (int i = 0; i < 10000; i++) begin
      v16_in_a = 16'($urandom); v16_in_b = 16'($urandom);
      if (i < 4) begin
        v16_in_a = (i % 2 == 0) ? 16'h8000 : 16'hFFFF;
        v16_in_b = v16_in_a;
      end
      v16_in_signed = 1'($urandom_range(0, 1));
      if (i < 4) v16_in_signed = 1'(i / 2);
      v16_in_tag = 4'(i);
      exp16_cur = ref_mul(16, v16_in_a, v16_in_b, v16_in_signed);
      v16_in_valid = 1;
      tick();
    end
    v16_in_valid = 0;
    repeat (5) tick();
    check("w16_drained", 32'(q16.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
